// File: rtl/key_schedule_seq.sv
// key_schedule_seq: iterative AES key expansion, one schedule word per cycle.
// Holds all round keys and serves them through a registered read port.
module key_schedule_seq #(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [32*NK-1:0] key_in,
  output logic            busy,
  output logic            done,
  output logic            keys_valid,
  input  logic [3:0]      rk_addr,
  output logic [127:0]    rk_out
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("key_schedule_seq: NK must be 4, 6 or 8");
  end

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t      state, state_nx;
  logic [5:0]  idx;
  logic [2:0]  imod;
  logic [7:0]  rcon;
  logic [31:0] w [NW];

  logic        accept, last;
  logic [5:0]  pi, ki;
  logic [31:0] prev, sin, sub, temp, nxt;
  logic [3:0]  ra;
  logic [5:0]  b0, b1, b2, b3;

  assign busy   = (state == EXPAND);
  assign accept = (state == IDLE) && start;
  assign last   = busy && (idx == 6'(NW - 1));

  assign pi   = idx - 6'd1;
  assign ki   = idx - 6'(NK);
  assign prev = w[pi];
  assign sin  = (imod == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  assign sub  = {sbox(sin[31:24]), sbox(sin[23:16]),
                 sbox(sin[15:8]),  sbox(sin[7:0])};

  // Schedule-word recurrence: pick temp by position within the key period
  always_comb begin
    temp = prev;
    if (imod == 3'd0)
      temp = sub ^ {rcon, 24'h0};
    else if (NK == 8 && imod == 3'd4)
      temp = sub;
    nxt = w[ki] ^ temp;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = EXPAND;
      EXPAND: if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, word counter, Rcon and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 6'd0;
      imod       <= 3'd0;
      rcon       <= 8'h00;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= last;
      if (accept) begin
        idx        <= 6'(NK);
        imod       <= 3'd0;
        rcon       <= 8'h01;
        keys_valid <= 1'b0;
      end else if (busy) begin
        idx  <= idx + 6'd1;
        imod <= (imod == 3'(NK - 1)) ? 3'd0 : imod + 3'd1;
        if (imod == 3'd0) rcon <= xtime(rcon);
        if (last) keys_valid <= 1'b1;
      end
    end
  end

  // Word store: key load on accept, one derived word per busy cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NK; k++)
        w[k] <= key_in[32*(NK-1-k) +: 32];
    end else if (busy) begin
      w[idx] <= nxt;
    end
  end

  assign ra = (rk_addr <= 4'(NR)) ? rk_addr : 4'd0;
  assign b0 = {ra, 2'b00};
  assign b1 = b0 + 6'd1;
  assign b2 = b0 + 6'd2;
  assign b3 = b0 + 6'd3;

  // Registered round-key read; zero unless a full schedule is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rk_out <= 128'h0;
    else if (keys_valid && rk_addr <= 4'(NR))
      rk_out <= {w[b0], w[b1], w[b2], w[b3]};
    else
      rk_out <= 128'h0;
  end

endmodule

// File: tb/tb_key_schedule_seq.sv
// tb_key_schedule_seq: scoreboard bench for key_schedule_seq.
// One instance per key length, shared clock and reset.
module tb_key_schedule_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start [3];
  logic [255:0] key   [3];
  logic [3:0]   addr  [3];
  logic         busy  [3];
  logic         done  [3];
  logic         kv    [3];
  logic [127:0] rko   [3];

  key_schedule_seq #(.NK(4)) u4 (
    .clk(clk), .rst(rst), .start(start[0]), .key_in(key[0][127:0]),
    .busy(busy[0]), .done(done[0]), .keys_valid(kv[0]),
    .rk_addr(addr[0]), .rk_out(rko[0]));

  key_schedule_seq #(.NK(6)) u6 (
    .clk(clk), .rst(rst), .start(start[1]), .key_in(key[1][191:0]),
    .busy(busy[1]), .done(done[1]), .keys_valid(kv[1]),
    .rk_addr(addr[1]), .rk_out(rko[1]));

  key_schedule_seq #(.NK(8)) u8 (
    .clk(clk), .rst(rst), .start(start[2]), .key_in(key[2][255:0]),
    .busy(busy[2]), .done(done[2]), .keys_valid(kv[2]),
    .rk_addr(addr[2]), .rk_out(rko[2]));

  localparam logic [255:0] K1 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K2 =
    256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int nrun = 0;
  int nfail = 0;
  logic [127:0] sbq [$];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    nrun++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input int d, input logic [3:0] a,
                    input logic [127:0] exp, input string tag);
    @(negedge clk);
    addr[d] = a;
    sbq.push_back(exp);
    @(posedge clk);
    #1;
    chk(tag, rko[d], sbq.pop_front());
  endtask

  task automatic expand(input int d, input logic [255:0] k, input int lat,
                        input int poke, input logic [255:0] pk,
                        input string tag);
    int n;
    int badkv;
    n = 0;
    badkv = 0;
    @(negedge clk);
    key[d] = k;
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    chk({tag, "-busy"}, 128'(busy[d]), 128'd1);
    chk({tag, "-kvlow"}, 128'(kv[d]), 128'd0);
    while (n < 200) begin
      @(negedge clk);
      if (n + 1 == poke) begin
        key[d] = pk;
        start[d] = 1'b1;
      end
      @(posedge clk);
      #1;
      start[d] = 1'b0;
      n++;
      if (n == 5) chk({tag, "-rdbusy"}, rko[d], 128'h0);
      if (done[d]) break;
      if (kv[d]) badkv++;
    end
    chk({tag, "-lat"}, 128'(n), 128'(lat));
    chk({tag, "-kvearly"}, 128'(badkv), 128'd0);
    chk({tag, "-kv"}, 128'(kv[d]), 128'd1);
    chk({tag, "-idle"}, 128'(busy[d]), 128'd0);
    @(posedge clk);
    #1;
    chk({tag, "-pulse"}, 128'(done[d]), 128'd0);
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      key[d] = '0;
      addr[d] = 4'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst-busy", 128'(busy[0]), 128'd0);
    chk("rst-done", 128'(done[0]), 128'd0);
    chk("rst-kv", 128'(kv[0]), 128'd0);
    chk("rst-rk", rko[0], 128'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 16; a++) rd(0, 4'(a), 128'h0, "rd-prevalid");

    expand(0, K1, 40, 0, '0, "v1");
    rd(0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "v1-rk1");
    rd(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "v1-rk10");
    rd(0, 4'd0, K1[127:0], "v1-rk0");
    rd(0, 4'd11, 128'h0, "v1-rk11");

    expand(1, K2, 46, 0, '0, "v2");
    rd(1, 4'd12, 128'he98ba06f448c773c8ecc720401002202, "v2-rk12");
    rd(1, 4'd13, 128'h0, "v2-rk13");

    expand(2, K3, 52, 0, '0, "v3");
    rd(2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "v3-rk14");

    expand(0, K1, 40, 10, K3, "v4poke");
    rd(0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "v4-rk1");
    rd(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "v4-rk10");
    expand(0, '0, 40, 0, '0, "v4zero");
    rd(0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "v4-zrk10");

    @(negedge clk);
    key[0] = K1;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst-busy", 128'(busy[0]), 128'd0);
    chk("mrst-kv", 128'(kv[0]), 128'd0);
    chk("mrst-rk", rko[0], 128'h0);
    chk("mrst-kv8", 128'(kv[2]), 128'd0);
    chk("mrst-rk8", rko[2], 128'h0);
    nd = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done[0]) nd++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (done[0]) nd++;
    end
    chk("mrst-nodone", 128'(nd), 128'd0);
    for (int a = 0; a < 16; a++) rd(0, 4'(a), 128'h0, "rd-afterrst");

    expand(0, K1, 40, 0, '0, "v5");
    rd(0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "v5-rk1");
    rd(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "v5-rk10");
    rd(0, 4'd0, K1[127:0], "v5-rk0");

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
